seq_sub_32bit: RTL

SEQ_SUB_32BIT -- requirements
Module: seq_sub_32bit

---
 rtl/seq_arith_pkg.sv | 15 +
 rtl/sub_slice_8.sv | 56 +++++
 rtl/seq_sub_32bit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seq_arith_pkg.sv
// seq_arith_pkg
// Shared definitions for the byte-serial arithmetic blocks.
//   state_t : controller states (IDLE, RUN, DONE)
//   BYTE_W  : width of one processed slice, in bits
package seq_arith_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_arith_pkg

// File: rtl/sub_slice_8.sv
// sub_slice_8
// Combinational 8-bit carry-lookahead adder slice. The caller presents the
// subtrahend already inverted, so a + b + cin performs one byte of a
// subtraction.
// Ports:
//   a    in  [7:0] minuend byte
//   b    in  [7:0] inverted subtrahend byte
//   cin  in        carry in (inverted borrow)
//   sum  out [7:0] result byte
//   cout out       carry out (inverted borrow)
module sub_slice_8
  import seq_arith_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] p;
  logic [BYTE_W-1:0] g;
  logic [BYTE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is built directly from p, g and cin as a sum of products:
  // a generate at bit j survives to bit i only if bits j+1..i-1 all
  // propagate. No carry depends on another carry, so there is no ripple.
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 1; i <= BYTE_W; i++) begin
      logic ci;
      logic term;
      ci = 1'b0;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        ci = ci | term;
      end
      term = cin;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = ci | term;
    end
  end

  assign sum  = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule : sub_slice_8

// File: rtl/seq_sub_32bit.sv
// seq_sub_32bit
// Byte-serial subtractor: computes diff_r = a - b - bin (mod 2^W) and the
// borrow out, one byte per clock, LSB first, with a valid/ready handshake on
// both sides. W = 8*NBYTES (NBYTES >= 2).
// Optional build macro: SEQ_SUB_OVF_FLAG_EN adds ovf_r, the signed
// two's-complement overflow flag of the subtraction.
// Ports:
//   clk        in         rising-edge clock
//   rst        in         asynchronous active-low reset
//   in_valid   in         operands present
//   in_ready   out        idle, operands accepted this cycle if in_valid
//   a, b       in  [W-1]  minuend, subtrahend (unsigned)
//   bin        in         borrow in
//   out_valid  out        result available
//   out_ready  in         consumer takes result
//   diff_r     out [W-1]  registered difference
//   bout_r     out        registered borrow out (a < b + bin)
//   ovf_r      out        signed overflow (only with SEQ_SUB_OVF_FLAG_EN)
module seq_sub_32bit
  import seq_arith_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   diff_r,
`ifdef SEQ_SUB_OVF_FLAG_EN
  output logic                  ovf_r,
`endif
  output logic                  bout_r
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES) + 1;

  state_t state;
  state_t next_state;

  logic [CW-1:0]       cnt;
  logic                carry;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        nb_sh;
  logic [W-BYTE_W-1:0] res_sh;

  logic [BYTE_W-1:0]   slice_sum;
  logic                slice_cout;
  logic [W-1:0]        res_next;
  logic                accept;
  logic                last_byte;

  // The low byte of each operand shift register is always the byte being
  // processed; the subtrahend is stored inverted so the slice simply adds.
  sub_slice_8 u_slice (
    .a    (a_sh[BYTE_W-1:0]),
    .b    (nb_sh[BYTE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Finished bytes enter at the top and move down, so after the last byte
  // the assembled word is already in its final position.
  assign res_next  = {slice_sum, res_sh};
  assign accept    = in_valid & in_ready;
  assign last_byte = (cnt == CW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs depend only on state, so in_ready is low for the whole
  // of DONE, including the cycle the result is taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_byte) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured only on the accept edge; the published result is
  // written only on the last byte, so it holds still for all of DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      nb_sh  <= '0;
      res_sh <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
`ifdef SEQ_SUB_OVF_FLAG_EN
      ovf_r  <= 1'b0;
`endif
    end else if (accept) begin
      cnt   <= '0;
      carry <= ~bin;
      a_sh  <= a;
      nb_sh <= ~b;
    end else if (state == RUN) begin
      cnt    <= cnt + CW'(1);
      carry  <= slice_cout;
      a_sh   <= a_sh >> BYTE_W;
      nb_sh  <= nb_sh >> BYTE_W;
      res_sh <= res_next[W-1:BYTE_W];
      if (last_byte) begin
        diff_r <= res_next;
        bout_r <= ~slice_cout;
`ifdef SEQ_SUB_OVF_FLAG_EN
        // On the last byte the slice inputs hold the operand sign bits;
        // nb_sh carries the inverted sign of b.
        ovf_r  <= (a_sh[BYTE_W-1] ^ ~nb_sh[BYTE_W-1]) &
                  (slice_sum[BYTE_W-1] ^ a_sh[BYTE_W-1]);
`endif
      end
    end
  end

endmodule : seq_sub_32bit
